decode_hazard_ctrl: RTL and testbench

//  Pipeline interlock/sequencing controller for the decode (ID) stage. Inspects the ID instruction
//  (opcode/rs/rt/funct fields) against the EX stage. Generates load-use stalls, multi-cycle MULT/DIV
//  (HI/LO) busy stalls and taken-branch/jump squashes. Drives IF/ID and ID/EX pipeline-register

---
 rtl/decode_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_decode_hazard_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage interlock controller: load-use and HI/LO busy stalls, branch/jump squashes,
// a HI/LO busy down-counter and a saturating stalled-cycle counter.
module decode_hazard_ctrl #(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32,
  parameter int CNT_W        = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        id_branch_taken,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_ex,
  output logic        flush_id,
  output logic        md_busy,
  output logic [15:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]       w_op;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [5:0]       w_funct;
  logic             w_uses_rs;
  logic             w_uses_rt;
  logic             w_is_md;
  logic             w_is_mf;
  logic             w_is_div;
  logic             w_is_jump;
  logic             w_load_use;
  logic             w_md_stall;
  logic             w_stall;
  logic             w_issue_md;
  logic             w_unused;
  logic [CNT_W-1:0] r_md_cnt;
  logic [15:0]      r_stall_count;

  assign w_op     = id_instr[31:26];
  assign w_rs     = id_instr[25:21];
  assign w_rt     = id_instr[20:16];
  assign w_funct  = id_instr[5:0];
  assign w_unused = ^id_instr[15:6];

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_uses_rs = 1'b1;
    w_uses_rt = 1'b0;
    w_is_md   = 1'b0;
    w_is_mf   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_uses_rt = 1'b1;
        case (w_funct)
          6'h00, 6'h02, 6'h03: w_uses_rs = 1'b0;
          6'h10, 6'h12: begin
            w_uses_rs = 1'b0;
            w_is_mf   = 1'b1;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: w_is_md = 1'b1;
          default: ;
        endcase
      end
      OP_J, OP_JAL:                       w_uses_rs = 1'b0;
      OP_BEQ, OP_BNE, OP_SW, OP_SH, OP_SB: w_uses_rt = 1'b1;
      default: ;
    endcase
  end

  assign w_is_div  = (w_funct == 6'h1A) || (w_funct == 6'h1B);
  assign w_is_jump = (w_op == OP_J) || (w_op == OP_JAL);

  assign w_load_use = id_valid && ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
                      ((w_uses_rs && (w_rs == ex_rt)) || (w_uses_rt && (w_rt == ex_rt)));
  assign w_md_stall = id_valid && (w_is_md || w_is_mf) && (r_md_cnt != '0);

  // Outputs are forced low while reset is asserted even if the ID/EX inputs show a hazard.
  assign w_stall    = rst_n && (w_load_use || w_md_stall);
  assign w_issue_md = id_valid && w_is_md && !w_stall;

  assign stall_if    = w_stall;
  assign stall_id    = w_stall;
  assign flush_ex    = w_stall;
  assign flush_id    = rst_n && id_valid && !w_stall && (id_branch_taken || w_is_jump);
  assign md_busy     = (r_md_cnt != '0);
  assign stall_count = r_stall_count;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt      <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_issue_md)
        r_md_cnt <= w_is_div ? CNT_W'(DIV_LATENCY) : CNT_W'(MULT_LATENCY);
      else if (r_md_cnt != '0)
        r_md_cnt <= r_md_cnt - 1'b1;

      if (w_stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: decode vector table plus multi-cycle
// mult/div, reset and saturation sequences, checked through an expectation queue.
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        id_valid, id_branch_taken, ex_valid, ex_mem_read;
  logic [4:0]  ex_rt;
  logic        stall_if, stall_id, flush_ex, flush_id, md_busy;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  typedef struct {
    logic  stall;
    logic  flush;
    logic  busy;
    string nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] instr;
    logic        v, br, exv, exmr;
    logic [4:0]  exrt;
    logic        s, f;
    string       nm;
  } vec_t;
  vec_t vecs[18];

  always #5 clk = ~clk;

  decode_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .id_branch_taken(id_branch_taken), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex),
    .flush_id(flush_id), .md_busy(md_busy), .stall_count(stall_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic v, input logic br,
                       input logic exv, input logic exmr, input logic [4:0] exrt);
    id_instr        = instr;
    id_valid        = v;
    id_branch_taken = br;
    ex_valid        = exv;
    ex_mem_read     = exmr;
    ex_rt           = exrt;
  endtask

  // Called just after a rising edge with inputs already applied; samples at the falling edge.
  task automatic cycle(input logic s, input logic f, input logic b, input string nm);
    exp_t e;
    sb.push_back('{stall: s, flush: f, busy: b, nm: nm});
    @(negedge clk);
    e = sb.pop_front();
    check({e.nm, ".stall_if"}, 32'(stall_if), 32'(e.stall));
    check({e.nm, ".stall_id"}, 32'(stall_id), 32'(e.stall));
    check({e.nm, ".flush_ex"}, 32'(flush_ex), 32'(e.stall));
    check({e.nm, ".flush_id"}, 32'(flush_id), 32'(e.flush));
    check({e.nm, ".md_busy"},  32'(md_busy),  32'(e.busy));
    check({e.nm, ".stall_count"}, 32'(stall_count), 32'(exp_cnt));
    @(posedge clk);
    if (e.stall && exp_cnt != 65535) exp_cnt++;
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic v, input logic br,
                              input logic exv, input logic exmr, input logic [4:0] exrt,
                              input logic s, input logic f, input string nm);
    vec_t r;
    r.instr = instr; r.v = v; r.br = br; r.exv = exv; r.exmr = exmr; r.exrt = exrt;
    r.s = s; r.f = f; r.nm = nm;
    return r;
  endfunction

  initial begin
    vecs[0]  = mk(32'h01095020, 1, 0, 1, 1, 5'd8,  1, 0, "add_lu_rs");
    vecs[1]  = mk(32'h01095020, 1, 0, 1, 1, 5'd0,  0, 0, "add_exrt0");
    vecs[2]  = mk(32'h01095020, 1, 0, 1, 1, 5'd9,  1, 0, "add_lu_rt");
    vecs[3]  = mk(32'h01095020, 1, 0, 1, 1, 5'd10, 0, 0, "add_rd_nohaz");
    vecs[4]  = mk(32'h01095020, 1, 0, 1, 0, 5'd8,  0, 0, "add_noload");
    vecs[5]  = mk(32'h01095020, 1, 0, 0, 1, 5'd8,  0, 0, "add_exinvalid");
    vecs[6]  = mk(32'h01095020, 0, 0, 1, 1, 5'd8,  0, 0, "add_bubble");
    vecs[7]  = mk(32'h11090004, 1, 1, 0, 0, 5'd0,  0, 1, "beq_taken");
    vecs[8]  = mk(32'h11090004, 1, 1, 1, 1, 5'd9,  1, 0, "beq_taken_lu");
    vecs[9]  = mk(32'h11090004, 1, 0, 0, 0, 5'd0,  0, 0, "beq_nottaken");
    vecs[10] = mk(32'h09000010, 1, 0, 1, 1, 5'd8,  0, 1, "j_ignores_rs");
    vecs[11] = mk(32'h0C000000, 1, 0, 0, 0, 5'd0,  0, 1, "jal");
    vecs[12] = mk(32'h0C000000, 0, 0, 0, 0, 5'd0,  0, 0, "jal_bubble");
    vecs[13] = mk(32'h01004080, 1, 0, 1, 1, 5'd8,  0, 0, "sll_ignores_rs");
    vecs[14] = mk(32'h8D090000, 1, 0, 1, 1, 5'd9,  0, 0, "lw_ignores_rt");
    vecs[15] = mk(32'h8D090000, 1, 0, 1, 1, 5'd8,  1, 0, "lw_lu_rs");
    vecs[16] = mk(32'hAD090000, 1, 0, 1, 1, 5'd9,  1, 0, "sw_lu_rt");
    vecs[17] = mk(32'h00005010, 1, 0, 0, 0, 5'd0,  0, 0, "mfhi_idle");

    rst_n = 1'b0;
    drive(32'h0, 0, 0, 0, 0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.stall_if", 32'(stall_if), 32'd0);
    check("reset.flush_id", 32'(flush_id), 32'd0);
    check("reset.md_busy", 32'(md_busy), 32'd0);
    check("reset.stall_count", 32'(stall_count), 32'd0);
    rst_n = 1'b1;

    // Single-cycle decode vectors, HI/LO unit idle.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].instr, vecs[i].v, vecs[i].br, vecs[i].exv, vecs[i].exmr, vecs[i].exrt);
      cycle(vecs[i].s, vecs[i].f, 1'b0, vecs[i].nm);
    end

    // mult then dependent mfhi: busy and stalled for MULT_LATENCY cycles, released after.
    drive(32'h01090018, 1, 0, 0, 0, 5'd0);
    cycle(0, 0, 0, "mult_issue");
    drive(32'h00005010, 1, 0, 0, 0, 5'd0);
    for (int i = 1; i <= 4; i++) cycle(1, 0, 1, $sformatf("mfhi_wait%0d", i));
    cycle(0, 0, 0, "mfhi_release");
    drive(32'h0, 0, 0, 0, 0, 5'd0);
    cycle(0, 0, 0, "mult_idle");

    // mult behind a busy mult with a concurrent load-use; blocked until both clear.
    drive(32'h01090018, 1, 0, 0, 0, 5'd0);
    cycle(0, 0, 0, "mult2_issue");
    drive(32'h01090018, 1, 0, 1, 1, 5'd8);
    for (int i = 1; i <= 4; i++) cycle(1, 0, 1, $sformatf("mult2_both%0d", i));
    cycle(1, 0, 0, "mult2_lu_only");
    drive(32'h01090018, 1, 0, 0, 0, 5'd0);
    cycle(0, 0, 0, "mult2_reissue");
    drive(32'h0, 0, 0, 0, 0, 5'd0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, $sformatf("mult2_drain%0d", i));
    cycle(0, 0, 0, "mult2_done");

    // div then div: second waits DIV_LATENCY cycles, then counter reloads to 32.
    drive(32'h0109001A, 1, 0, 0, 0, 5'd0);
    cycle(0, 0, 0, "div_issue");
    for (int i = 1; i <= 32; i++) cycle(1, 0, 1, $sformatf("div2_wait%0d", i));
    cycle(0, 0, 0, "div2_issue");
    drive(32'h0, 0, 0, 0, 0, 5'd0);
    for (int i = 1; i <= 32; i++) cycle(0, 0, 1, $sformatf("div2_busy%0d", i));
    cycle(0, 0, 0, "div2_done");

    // Asynchronous reset while the divide counter sits at 17.
    drive(32'h0109001A, 1, 0, 0, 0, 5'd0);
    cycle(0, 0, 0, "rdiv_issue");
    drive(32'h00005010, 1, 0, 0, 0, 5'd0);
    for (int i = 1; i <= 15; i++) cycle(1, 0, 1, $sformatf("rdiv_wait%0d", i));
    drive(32'h01095020, 1, 0, 1, 1, 5'd8);
    #2;
    check("rdiv_pre.md_busy", 32'(md_busy), 32'd1);
    check("rdiv_pre.stall_if", 32'(stall_if), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rdiv_rst.md_busy", 32'(md_busy), 32'd0);
    check("rdiv_rst.stall_if", 32'(stall_if), 32'd0);
    check("rdiv_rst.stall_id", 32'(stall_id), 32'd0);
    check("rdiv_rst.flush_ex", 32'(flush_ex), 32'd0);
    check("rdiv_rst.flush_id", 32'(flush_id), 32'd0);
    check("rdiv_rst.stall_count", 32'(stall_count), 32'd0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(32'h0, 0, 0, 0, 0, 5'd0);
    cycle(0, 0, 0, "post_reset");

    // Saturation: hold a load-use hazard for more than 65535 cycles.
    drive(32'h01095020, 1, 0, 1, 1, 5'd8);
    repeat (66000) @(posedge clk);
    #1;
    check("sat.stall_count", 32'(stall_count), 32'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    check("sat_hold.stall_count", 32'(stall_count), 32'hFFFF);
    check("sat_hold.stall_if", 32'(stall_if), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
